alu: RTL and testbench
======================

# alu

32-bit MIPS-style arithmetic/logic unit for the single-cycle datapath, sitting between the register file/immediate mux (A, B) and the data-memory address / write-back path. It decodes a 3-bit ALUControl into AND, OR, ADD, AND-NOT, OR-NOT, SUB and SLT. It produces the result and a Zero flag for branch decisions. A clocked status section keeps a sticky signed-overflow flag.

## Interface
- WIDTH, 32, datapath width in bits. All arithmetic rules below are stated for WIDTH.
- clk  input  1  rising-edge clock; used only by the status register (and the output register when ALU_OUTPUT_REG_EN is defined).
- rst_n  input  1  asynchronous, active-low reset.
- A  input  WIDTH  first operand, rs.
- B  input  WIDTH  second operand, rt or sign-extended immediate.
- ALUControl  input  3  operation select.
- ALUResult  output  WIDTH  operation result.
- Zero  output  1  high when ALUResult == 0.
- Overflow  output  1  signed overflow of the current ADD or SUB. It is 0 for all other operations.
- OvfSticky  output  1  registered; set by any cycle with Overflow=1; cleared only by reset or ovf_clr.
- ovf_clr  input  1  synchronous clear of OvfSticky. Clear has priority over set in the same cycle.

## Operation
- 000 AND: A & B.
- 001 OR: A | B.
- 010 ADD: A + B, modulo 2^WIDTH.
- 011 reserved: result 0, so Zero=1.
- 100 AND-NOT: A & ~B.
- 101 OR-NOT: A | ~B.
- 110 SUB: A + ~B + 1, modulo 2^WIDTH.
- 111 SLT: result 1 if signed(A) < signed(B), else 0.
- Implementation uses one shared adder. For ALUControl[2]=1, B is inverted and carry-in is 1.
- SLT must use the true signed comparison, sum MSB XOR overflow, so that it is correct across overflow.
- Overflow for ADD/SUB is set when both adder inputs have the same sign and the sum sign differs. Carry-out is ignored.
- Zero is derived from the final ALUResult. This includes SLT and the reserved code.
- Any X on ALUControl produces no latch. The case statement is full, with a default of 0.

## Timing
- Without ALU_OUTPUT_REG_EN:
  - ALUResult, Zero and Overflow are purely combinational, with 0-cycle latency.
  - They are independent of clk and rst_n.
- OvfSticky:
  - Reset value 0, cleared asynchronously the moment rst_n goes low.
  - Updates on the rising clk edge: next = ovf_clr ? 0 : (OvfSticky | Overflow).
  - Reset asserted mid-operation forces 0 immediately, regardless of inputs.
- Operand or ALUControl changes take effect on the combinational outputs within the same cycle. No handshake is required.

## Configuration
- ALU_OUTPUT_REG_EN:
  - Defined: ALUResult, Zero and Overflow are registered on the rising clk edge, giving 1-cycle latency. Reset values are ALUResult=0, Zero=1 and Overflow=0. OvfSticky then samples the registered Overflow.
  - Undefined: these outputs are combinational, as described above.

## Structure
- Shared package alu_pkg holds:
  - the ALUControl encodings as named constants: ALU_AND, ALU_OR, ALU_ADD, ALU_RSVD, ALU_ANDN, ALU_ORN, ALU_SUB, ALU_SLT;
  - the WIDTH default.
- One natural sub-module: alu_adder, the WIDTH-bit adder with invert-B/carry-in. It returns the sum, the sum MSB and the overflow bit.
- The top level contains the operation mux, Zero detect and the status/output registers.

## Test plan
- A=0x00001345, B=0x0000C134, sweep ALUControl 000,001,010,100,101,110,111. Required ALUResult sequence: 0x00000104, 0x0000D375, 0x0000D479, 0x00001241, 0xFFFF3FCF, 0xFFFF5211, 0x00000001. Zero=0 throughout.
- A=0x7FFFFFFF, B=1, ADD -> 0x80000000 with Overflow=1. OvfSticky is 1 after the next clk edge and stays 1 after the operands change.
- A=0x80000000, B=1, SLT -> 1, since most-negative < 1. Swapping the operands -> 0. SUB with the operands swapped (A=1, B=0x80000000) -> 0x80000001 with Overflow=1.
- A=B=0x12345678, SUB -> ALUResult=0, Zero=1. ALUControl=011 with any operands -> 0, Zero=1.
- Hold OvfSticky=1 and pulse rst_n low between clock edges -> OvfSticky drops to 0 immediately. Raise ovf_clr in the same cycle as Overflow=1 -> OvfSticky=0 after the edge.
- With ALU_OUTPUT_REG_EN defined, repeat the first scenario. Each result must appear one clk edge after its ALUControl is applied. The post-reset output must be ALUResult=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the MIPS-style ALU: ALUControl encodings and the default datapath width.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_RSVD = 3'b011;
    localparam logic [2:0] ALU_ANDN = 3'b100;
    localparam logic [2:0] ALU_ORN  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage

// File: rtl/alu_adder.sv
// Shared WIDTH-bit adder: optional B inversion with carry-in, reporting sum, sum MSB and
// signed overflow (carry-out is intentionally not produced).
module alu_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             sum_msb,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff   = sub ? ~b : b;
    assign sum     = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    assign sum_msb = sum[WIDTH-1];
    // Overflow: both adder inputs share a sign that the sum does not.
    assign ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 32-bit MIPS-style ALU with Zero flag and sticky signed-overflow status.
// Define ALU_OUTPUT_REG_EN to register ALUResult/Zero/Overflow (1-cycle latency).
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             OvfSticky
);

    logic [WIDTH-1:0] sum;
    logic             sum_msb;
    logic             add_ovf;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic             sticky_q;

    alu_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a      (A),
        .b      (B),
        .sub    (ALUControl[2]),
        .sum    (sum),
        .sum_msb(sum_msb),
        .ovf    (add_ovf)
    );

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (ALUControl)
            ALU_AND:  result_d = A & B;
            ALU_OR:   result_d = A | B;
            ALU_ADD:  begin
                result_d = sum;
                ovf_d    = add_ovf;
            end
            ALU_RSVD: result_d = '0;
            ALU_ANDN: result_d = A & ~B;
            ALU_ORN:  result_d = A | ~B;
            ALU_SUB:  begin
                result_d = sum;
                ovf_d    = add_ovf;
            end
            // True signed less-than, valid even when the subtraction overflows.
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, sum_msb ^ add_ovf};
            default:  result_d = '0;
        endcase
    end

`ifdef ALU_OUTPUT_REG_EN
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= (result_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
`else
    assign ALUResult = result_d;
    assign Zero      = (result_d == '0);
    assign Overflow  = ovf_d;
`endif

    // Clear wins over a same-cycle overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (ovf_clr) begin
            sticky_q <= 1'b0;
        end else if (Overflow) begin
            sticky_q <= 1'b1;
        end
    end

    assign OvfSticky = sticky_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, sticky/reset sequences and randomized
// operands against an arithmetic reference model. Honours ALU_OUTPUT_REG_EN.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  ALUControl;
    logic        ovf_clr;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Overflow;
    logic        OvfSticky;

    int n_tests = 0;
    int n_fail  = 0;

    localparam longint MaxS = 64'sd2147483647;
    localparam longint MinS = -64'sd2147483648;

    alu #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .ALUControl(ALUControl),
        .ovf_clr   (ovf_clr),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .OvfSticky (OvfSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] c, output logic [31:0] r,
                                      output logic o);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        s  = 0;
        r  = 32'h0;
        o  = 1'b0;
        case (c)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = sa + sb;
                r = s[31:0];
                o = (s > MaxS) || (s < MinS);
            end
            3'd4: r = a & ~b;
            3'd5: r = a | ~b;
            3'd6: begin
                s = sa - sb;
                r = s[31:0];
                o = (s > MaxS) || (s < MinS);
            end
            3'd7: r = (sa < sb) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
    endfunction

    logic [31:0] now_res;
    logic        now_ovf;
    always_comb ref_model(A, B, ALUControl, now_res, now_ovf);

    // Expected registered outputs and sticky flag.
    logic [31:0] m_res_q;
    logic        m_zero_q;
    logic        m_ovf_q;
    logic        m_sticky;

`ifdef ALU_OUTPUT_REG_EN
    localparam bit RegOut = 1'b1;
`else
    localparam bit RegOut = 1'b0;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res_q  <= 32'h0;
            m_zero_q <= 1'b1;
            m_ovf_q  <= 1'b0;
            m_sticky <= 1'b0;
        end else begin
            m_res_q  <= now_res;
            m_zero_q <= (now_res == 32'h0);
            m_ovf_q  <= now_ovf;
            m_sticky <= ovf_clr ? 1'b0 : (m_sticky | (RegOut ? m_ovf_q : now_ovf));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name);
        logic [31:0] er;
        logic        ez;
        logic        eo;
        er = RegOut ? m_res_q : now_res;
        ez = RegOut ? m_zero_q : (now_res == 32'h0);
        eo = RegOut ? m_ovf_q : now_ovf;
        chk({name, ".result"}, ALUResult, er);
        chk({name, ".zero"}, {31'h0, Zero}, {31'h0, ez});
        chk({name, ".ovf"}, {31'h0, Overflow}, {31'h0, eo});
        chk({name, ".sticky"}, {31'h0, OvfSticky}, {31'h0, m_sticky});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        A          = a;
        B          = b;
        ALUControl = c;
    endtask

    // Called one time unit after a rising edge; returns one unit after the next one.
    task automatic tick(input logic clr);
        ovf_clr = clr;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
    endtask

    // Wait until the just-driven operation is visible on the outputs.
    task automatic settle();
`ifdef ALU_OUTPUT_REG_EN
        tick(1'b0);
`else
        #1;
`endif
    endtask

    task automatic step_done();
`ifndef ALU_OUTPUT_REG_EN
        tick(1'b0);
`endif
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctl;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{32'h00001345, 32'h0000C134, 3'b000, 32'h00000104, 1'b0};
        vecs[1]  = '{32'h00001345, 32'h0000C134, 3'b001, 32'h0000D375, 1'b0};
        vecs[2]  = '{32'h00001345, 32'h0000C134, 3'b010, 32'h0000D479, 1'b0};
        vecs[3]  = '{32'h00001345, 32'h0000C134, 3'b100, 32'h00001241, 1'b0};
        vecs[4]  = '{32'h00001345, 32'h0000C134, 3'b101, 32'hFFFF3FCF, 1'b0};
        vecs[5]  = '{32'h00001345, 32'h0000C134, 3'b110, 32'hFFFF5211, 1'b0};
        vecs[6]  = '{32'h00001345, 32'h0000C134, 3'b111, 32'h00000001, 1'b0};
        vecs[7]  = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b1};
        vecs[8]  = '{32'h80000000, 32'h00000001, 3'b111, 32'h00000001, 1'b0};
        vecs[9]  = '{32'h00000001, 32'h80000000, 3'b111, 32'h00000000, 1'b0};
        vecs[10] = '{32'h00000001, 32'h80000000, 3'b110, 32'h80000001, 1'b1};
        vecs[11] = '{32'h12345678, 32'h12345678, 3'b110, 32'h00000000, 1'b0};
        vecs[12] = '{32'hDEADBEEF, 32'hCAFEF00D, 3'b011, 32'h00000000, 1'b0};
        vecs[13] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 3'b110, 32'h80000000, 1'b1};

        rst_n   = 1'b0;
        ovf_clr = 1'b0;
        drive(32'h00001234, 32'h00005678, 3'b010);
        #12;
        check_all("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ctl);
            settle();
            chk($sformatf("vec%0d.result", i), ALUResult, vecs[i].res);
            chk($sformatf("vec%0d.zero", i), {31'h0, Zero}, {31'h0, vecs[i].res == 32'h0});
            chk($sformatf("vec%0d.ovf", i), {31'h0, Overflow}, {31'h0, vecs[i].ovf});
            step_done();
        end

        // Sticky set by an overflow and held after the operands change.
        drive(32'h7FFFFFFF, 32'h00000001, 3'b010);
        settle();
        tick(1'b0);
        chk("sticky_set", {31'h0, OvfSticky}, 32'h1);
        drive(32'h00000001, 32'h00000001, 3'b010);
        tick(1'b0);
        tick(1'b0);
        chk("sticky_hold", {31'h0, OvfSticky}, 32'h1);
        check_all("sticky_hold_all");

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {31'h0, OvfSticky}, 32'h0);
        check_all("async_rst_all");
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clear beats a same-cycle overflow.
        drive(32'h00000001, 32'h80000000, 3'b110);
        settle();
        tick(1'b1);
        chk("clr_prio", {31'h0, OvfSticky}, 32'h0);
        check_all("clr_prio_all");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 3) == 0) ra = {$urandom_range(0, 1) == 1, {31{ra[0]}}};
            if ($urandom_range(0, 3) == 0) rb = {$urandom_range(0, 1) == 1, {31{rb[0]}}};
            drive(ra, rb, 3'($urandom_range(0, 7)));
            settle();
            check_all("rand");
            tick($urandom_range(0, 7) == 0);
            check_all("rand_post");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
